maze_rom_arbiter: RTL
=====================

Name: maze_rom_arbiter

Overview:
- Shares the single-port, synchronous-read maze ROM between two kinds of user: the pixel fetch path that feeds color_mapper, and NUM_REQ game-logic requesters (Pac-Man and ghost wall/collision probes).
- Converts (x,y) coordinates into the linear ROM address, y*COLS + x.
- Schedules one ROM read per Clk cycle. The pixel path has strict priority; the game requesters are served round-robin.
- Returns each read result with a fixed latency.

Parameters:
- NUM_REQ, 4, number of game-logic requesters.
- COLS, 640, maze row width in pixels; used as the address stride.
- ROWS, 480, maze height in pixels; used for the range check.
- ADDR_W, 19, ROM address width.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high reset.
- pix_req  in  1  pixel path requests a read this cycle.
- pix_x  in  10  pixel column (DrawX).
- pix_y  in  10  pixel row (DrawY).
- pix_valid  out  1  pixel result valid.
- pix_data  out  1  pixel result; 1 = wall.
- req  in  NUM_REQ  game request lines, one per requester.
- req_x  in  10*NUM_REQ  packed x coordinates; requester i uses bits [10i+9:10i].
- req_y  in  10*NUM_REQ  packed y coordinates, same packing.
- gnt  out  NUM_REQ  one-hot grant pulse.
- rsp_valid  out  NUM_REQ  one-hot response-valid pulse.
- rsp_data  out  1  shared game response data; 1 = wall.
- rom_addr  out  ADDR_W  registered ROM read address.
- rom_data  in  1  ROM output, valid one cycle after rom_addr.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is asynchronous and active-high.
  - Reset clears: rom_addr=0, gnt=0, rsp_valid=0, pix_valid=0, pix_data=0, rsp_data=0, rr_ptr=0, all pending bits and all pipeline stages.
- Arbitration (edge E, using inputs sampled at E):
  - If pix_req=1, the pixel path wins.
  - Otherwise the winner is the first eligible requester, searching upward from rr_ptr with wrap-around.
  - Eligible means req[i]=1 and pending[i]=0.
  - When a game requester wins: rr_ptr <= winner+1 mod NUM_REQ, and pending[winner] is set.
  - If nothing wins, no ROM access occurs, rom_addr holds its value, and the stage-1 valid bit is 0.
- Stage 1 (registered at E, visible during cycle E..E+1):
  - rom_addr <= y*COLS + x, computed full-width, then truncated to ADDR_W bits.
  - gnt[winner] = 1 for exactly one cycle; never set for a pixel win.
  - The owner tag (pixel or index i) and an out-of-range flag (x>=COLS or y>=ROWS) are registered alongside.
  - Out of range: rom_addr is not updated.
- Stage 2 (edge E+2):
  - Pixel owner: pix_valid=1, pix_data=rom_data. If out of range, pix_data=0 (floor).
  - Game owner i: rsp_valid[i]=1, rsp_data=rom_data. If out of range, rsp_data=1 (wall).
  - pending[i] is cleared at this same edge.
- Latency and throughput:
  - Total latency is 2 cycles from the sampled request to the valid pulse.
  - One access per cycle, fully pipelined.
- Requester rules:
  - Hold req and coordinates stable until gnt is seen.
  - Deassert req no later than the cycle after the rsp_valid pulse.
  - req asserted while pending[i]=1 is ignored, so there is no double issue.
  - Coordinates are captured only at the grant edge.
- Starvation: a continuously asserted pix_req starves game requesters. By design pix_req is low during blanking and on alternate cycles (VGA_CLK = Clk/2), so game requesters get access then.
- Simultaneous events: if a pending clear and a new request from the same requester fall on the same edge, the requester is treated as still pending. It becomes eligible at the next edge.
- Reset mid-operation: in-flight reads are dropped with no valid pulse, and pending bits are cleared.

Test Plan:
- Reset asserted asynchronously mid-cycle -> all outputs 0 immediately; rr_ptr=0.
- pix_req with (3,2) at edge E -> rom_addr=1283 after E; with rom_data=1, pix_valid=1 and pix_data=1 for exactly one cycle after E+2; gnt stays 0.
- pix_req and req[0] both asserted at E -> pixel is served at E; gnt[0] pulses after E+1; rsp_valid[0] pulses after E+3.
- req=4'b1111 held, with each requester dropping req after its rsp_valid -> grants issue in order 0,1,2,3 on consecutive cycles. Then req[1] and req[3] re-asserted with rr_ptr=0 -> 1 is granted before 3.
- req[2] with x=640, y=5 -> rsp_valid[2] pulses 2 cycles later with rsp_data=1; rom_addr is unchanged. pix_req with y=480 -> pix_data=0.
- Full pixel pipeline in flight when Reset pulses -> no pix_valid or rsp_valid appears afterwards; pending=0; a fresh req[0] is granted on the first edge after Reset is released.

Source files
------------

// File: rtl/maze_rom_arbiter.sv
// Shares the synchronous-read maze ROM between the pixel fetch path (strict priority)
// and NUM_REQ round-robin game requesters; two-cycle fixed-latency responses.
module maze_rom_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned COLS    = 640,
  parameter int unsigned ROWS    = 480,
  parameter int unsigned ADDR_W  = 19
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    pix_req,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  output logic                    pix_valid,
  output logic                    pix_data,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [10*NUM_REQ-1:0]   req_x,
  input  logic [10*NUM_REQ-1:0]   req_y,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic                    rsp_data,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic                    rom_data
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]      r_rr_ptr;
  logic [NUM_REQ-1:0] r_pending;
  logic               r_s1_valid, r_s1_pix, r_s1_oor;
  logic [IW-1:0]      r_s1_idx;
  logic               r_s2_valid, r_s2_pix, r_s2_oor;
  logic [IW-1:0]      r_s2_idx;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_game_found;
  logic [IW-1:0]      w_win;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic [9:0]         w_x, w_y;
  logic               w_oor;
  logic [ADDR_W-1:0]  w_addr;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [NUM_REQ-1:0] w_s2_oh;

  // Round-robin search upward from r_rr_ptr; a requester still pending is not eligible.
  always_comb begin
    w_elig       = req & ~r_pending;
    w_game_found = 1'b0;
    w_win        = '0;
    w_idx        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = IW'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_game_found && w_elig[w_idx]) begin
        w_game_found = 1'b1;
        w_win        = w_idx;
      end
    end
  end

  always_comb begin
    w_any    = pix_req | w_game_found;
    w_x      = pix_req ? pix_x : req_x[10*w_win +: 10];
    w_y      = pix_req ? pix_y : req_y[10*w_win +: 10];
    w_oor    = (32'(w_x) >= COLS) || (32'(w_y) >= ROWS);
    w_addr   = ADDR_W'(32'(w_y) * COLS + 32'(w_x));
    w_win_oh = (!pix_req && w_game_found) ? (NUM_REQ'(1) << w_win) : '0;
    w_s2_oh  = (r_s2_valid && !r_s2_pix) ? (NUM_REQ'(1) << r_s2_idx) : '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rr_ptr   <= '0;
      r_pending  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_pix   <= 1'b0;
      r_s1_oor   <= 1'b0;
      r_s1_idx   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_pix   <= 1'b0;
      r_s2_oor   <= 1'b0;
      r_s2_idx   <= '0;
      rom_addr   <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= 1'b0;
    end else begin
      gnt       <= w_win_oh;
      r_pending <= (r_pending & ~w_s2_oh) | w_win_oh;
      if (|w_win_oh) begin
        r_rr_ptr <= (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      end
      if (w_any && !w_oor) begin
        rom_addr <= w_addr;
      end
      r_s1_valid <= w_any;
      r_s1_pix   <= pix_req;
      r_s1_idx   <= w_win;
      r_s1_oor   <= w_oor;
      // Tag delay stage lines up with the ROM's one-cycle read latency.
      r_s2_valid <= r_s1_valid;
      r_s2_pix   <= r_s1_pix;
      r_s2_idx   <= r_s1_idx;
      r_s2_oor   <= r_s1_oor;
      pix_valid  <= r_s2_valid && r_s2_pix;
      rsp_valid  <= w_s2_oh;
      // Off-maze reads: pixels see floor, game probes see wall.
      if (r_s2_valid && r_s2_pix) begin
        pix_data <= !r_s2_oor && rom_data;
      end
      if (r_s2_valid && !r_s2_pix) begin
        rsp_data <= r_s2_oor || rom_data;
      end
    end
  end

endmodule
